ofmap_bram_reader: RTL and testbench
====================================

# ofmap_bram_reader

Drain engine for the output-feature-map BRAM (mem2). After the GEMM core has written mem2 through port 0 and raised its finish flag, this block reads mem2 through port 1 in ascending address order and streams each 112-bit word (fourteen 8-bit activations) to a downstream consumer over a valid/ready handshake. It replaces the bench-only mem2 dump loop with synthesizable hardware that sustains one word per cycle and honours backpressure.

## Interface
Parameters:
- DATA_WIDTH, 8, activation element width
- PE_SIZE, 14, elements per word
- MEM2_DATA_WIDTH, 112, word width (= DATA_WIDTH*PE_SIZE)
- MEM2_ADDR_WIDTH, 10, mem2 address width
- MEM2_DEPTH, 896, mem2 word count

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start_i  in  1  start pulse; sampled only in IDLE
- num_words_i  in  MEM2_ADDR_WIDTH+1  words to drain from address 0; latched on accepted start; values above MEM2_DEPTH are clamped to MEM2_DEPTH
- mem2_ce1  out  1  mem2 port-1 chip enable
- mem2_we1  out  1  mem2 port-1 write enable, constant 0
- mem2_addr1  out  MEM2_ADDR_WIDTH  mem2 port-1 read address
- mem2_q1_i  in  MEM2_DATA_WIDTH  mem2 port-1 read data, valid 1 cycle after ce
- m_valid_o  out  1  output word valid
- m_data_o  out  MEM2_DATA_WIDTH  output word; element 0 in bits [111:104]
- m_last_o  out  1  qualifies the final word
- m_ready_i  in  1  consumer ready
- busy_o  out  1  high from accepted start until done
- done_o  out  1  one-cycle pulse after the last handshake

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE: start_i=1 latches N (clamped num_words_i), clears rd_addr, and moves to READ when N>0. When N=0, it moves to DONE instead.
- READ: issue a read (ce1=1, addr1=rd_addr) when credit allows. Credit condition: fifo_count + inflight − pop < 2, where pop = m_valid_o & m_ready_i. Each issue increments rd_addr. After issuing read N−1, go to DRAIN.
- Read data returns one cycle after issue (inflight flag). It is pushed into a 2-entry FIFO on the following edge.
- DRAIN: no reads issued. Stay until the handshake with m_last_o=1, then go to DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- Output signals come straight from the FIFO head: m_valid_o = FIFO non-empty, and m_last_o = the head word's sequence index equals N−1. A sequence counter increments on each pop.
- Once m_valid_o is high, m_data_o stays stable until accepted (AXI-style). m_valid_o never depends on m_ready_i.
- start_i is ignored outside IDLE. num_words_i is ignored except on an accepted start.
- mem2_we1 is 0 at all times. The block never writes mem2.
- Addresses never wrap: the largest address issued is N−1 ≤ MEM2_DEPTH−1.

## Timing
- Reset values: mem2_ce1=0, mem2_we1=0, mem2_addr1=0, m_valid_o=0, m_data_o=0, m_last_o=0, busy_o=0, done_o=0. FIFO, counters and inflight are cleared; state is IDLE.
- Reset mid-drain aborts immediately. Outputs take reset values, and no done_o is emitted.
- With start accepted at edge E0: ce1 (addr 0) is driven in cycle E0→E1, q is valid after E1, it is pushed at E2, and m_valid_o rises after E2. Latency from start to first valid is 2 cycles.
- With m_ready_i held at 1: one word per cycle and N consecutive valid cycles. done_o is high in the cycle after the last handshake, and busy_o falls with it.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- Backpressure: with m_ready_i=0, at most 2 words are buffered and no further reads are issued. No data is lost or duplicated.
- N=0: busy_o high for 1 cycle, done_o pulses the cycle after start, and m_valid_o is never asserted.

## Structure
- Shared package gemm_pkg: DATA_WIDTH, PE_SIZE, MEM2_* constants, and the FSM state enum (rd_state_t).
- Sub-module sync_fifo2: 2-entry, MEM2_DATA_WIDTH plus a last-bit. Push/pop/full/empty, with simultaneous push/pop support.
- Top level holds the FSM, address/sequence counters, the inflight flag, and the credit logic.

## Test plan
- Preload mem2[k] = {14{k[7:0]}}, N=896, ready always 1. Expect 896 consecutive words with data matching the address. m_last_o on word 895; done_o one cycle later.
- Same preload, N=896, ready toggling 1,0,0,1 pseudo-randomly. Expect word order 0..895 with no gaps or duplicates, data stable while stalled, and ce1 never issued with 2 words buffered.
- N=1. Expect a single word mem2[0] with m_last_o=1 on it, then a done_o pulse.
- N=0, then N=1000. First: done_o with no valid. Second: clamped to 896 words, no address ≥896.
- Pulse start_i at word 100 of an active drain. Expect it ignored and the sequence unchanged.
- Deassert rst_n at word 300 for 2 cycles, then start again with N=10. Expect all outputs at reset values and no done_o during reset, then words 0..9 and done_o.

Source files
------------

// File: rtl/gemm_pkg.sv
// Shared GEMM datapath constants and the mem2 drain FSM state type.
package gemm_pkg;
  localparam int DATA_WIDTH      = 8;
  localparam int PE_SIZE         = 14;
  localparam int MEM2_DATA_WIDTH = DATA_WIDTH * PE_SIZE;
  localparam int MEM2_ADDR_WIDTH = 10;
  localparam int MEM2_DEPTH      = 896;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } rd_state_t;
endpackage

// File: rtl/sync_fifo2.sv
// Two-entry FIFO carrying one word plus its end-of-stream flag. Push and pop
// in the same cycle are accepted even when the FIFO is full.
module sync_fifo2
  import gemm_pkg::*;
#(
  parameter int WIDTH = MEM2_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_push_last,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_data,
  output logic             o_head_last,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH:0] r_mem [2];
  logic           r_wr_ptr;
  logic           r_rd_ptr;
  logic [1:0]     r_count;
  logic           w_do_push;
  logic           w_do_pop;

  assign o_full    = (r_count == 2'd2);
  assign o_empty   = (r_count == 2'd0);
  assign w_do_pop  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot that a push into a full FIFO needs.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  assign {o_head_last, o_head_data} = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= {i_push_last, i_push_data};
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ofmap_bram_reader.sv
// Drains mem2 through port 1 in ascending address order and streams each word
// to a valid/ready consumer, one word per cycle, holding at most two in flight.
module ofmap_bram_reader #(
  parameter int DATA_WIDTH      = gemm_pkg::DATA_WIDTH,
  parameter int PE_SIZE         = gemm_pkg::PE_SIZE,
  parameter int MEM2_DATA_WIDTH = DATA_WIDTH * PE_SIZE,
  parameter int MEM2_ADDR_WIDTH = gemm_pkg::MEM2_ADDR_WIDTH,
  parameter int MEM2_DEPTH      = gemm_pkg::MEM2_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic [MEM2_ADDR_WIDTH:0]   num_words_i,
  output logic                       mem2_ce1,
  output logic                       mem2_we1,
  output logic [MEM2_ADDR_WIDTH-1:0] mem2_addr1,
  input  logic [MEM2_DATA_WIDTH-1:0] mem2_q1_i,
  output logic                       m_valid_o,
  output logic [MEM2_DATA_WIDTH-1:0] m_data_o,
  output logic                       m_last_o,
  input  logic                       m_ready_i,
  output logic                       busy_o,
  output logic                       done_o
);
  import gemm_pkg::*;

  localparam int            CW       = MEM2_ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LP_DEPTH = CW'(MEM2_DEPTH);

  rd_state_t                  r_state;
  rd_state_t                  w_state_next;
  logic [CW-1:0]              r_num_words;
  logic [CW-1:0]              r_seq;
  logic [MEM2_ADDR_WIDTH-1:0] r_rd_addr;
  logic                       r_inflight;
  logic                       r_inflight_last;

  logic [CW-1:0]              w_num_clamped;
  logic [CW-1:0]              w_last_idx;
  logic                       w_start_ok;
  logic                       w_issue;
  logic                       w_issue_last;
  logic                       w_seq_last;
  logic                       w_pop;
  logic                       w_credit;
  logic [1:0]                 w_occupancy;
  logic                       w_fifo_full;
  logic                       w_fifo_empty;
  logic                       w_head_last;
  logic [MEM2_DATA_WIDTH-1:0] w_head_data;

  assign w_num_clamped = (num_words_i > LP_DEPTH) ? LP_DEPTH : num_words_i;
  assign w_last_idx    = r_num_words - CW'(1);
  assign w_start_ok    = (r_state == IDLE) && start_i;
  assign w_pop         = m_valid_o & m_ready_i;
  assign w_occupancy   = {w_fifo_full, ~w_fifo_full & ~w_fifo_empty};

  // Words buffered plus the one in flight, less this cycle's pop, stay below two.
  assign w_credit     = ({1'b0, w_occupancy} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
  assign w_issue      = (r_state == READ) && w_credit;
  assign w_issue_last = ({1'b0, r_rd_addr} == w_last_idx);
  assign w_seq_last   = (r_seq == w_last_idx);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start_i) w_state_next = (w_num_clamped == '0) ? DONE : READ;
      READ:    if (w_issue && w_issue_last) w_state_next = DRAIN;
      DRAIN:   if (w_pop && w_seq_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_num_words     <= '0;
      r_seq           <= '0;
      r_rd_addr       <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue & w_issue_last;
      if (w_start_ok) begin
        r_num_words <= w_num_clamped;
        r_seq       <= '0;
        r_rd_addr   <= '0;
      end else begin
        if (r_state == DONE) begin
          r_rd_addr <= '0;
        end else if (w_issue) begin
          r_rd_addr <= r_rd_addr + MEM2_ADDR_WIDTH'(1);
        end
        if (w_pop) begin
          r_seq <= r_seq + CW'(1);
        end
      end
    end
  end

  // Read data is valid the cycle after issue; capture it on the following edge.
  sync_fifo2 #(
    .WIDTH(MEM2_DATA_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (r_inflight),
    .i_push_data(mem2_q1_i),
    .i_push_last(r_inflight_last),
    .i_pop      (w_pop),
    .o_head_data(w_head_data),
    .o_head_last(w_head_last),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty)
  );

  assign mem2_ce1   = w_issue;
  assign mem2_we1   = 1'b0;
  assign mem2_addr1 = r_rd_addr;
  assign m_valid_o  = ~w_fifo_empty;
  assign m_data_o   = w_head_data;
  assign m_last_o   = m_valid_o & w_head_last;
  assign busy_o     = (r_state != IDLE);
  assign done_o     = (r_state == DONE);

endmodule

// File: tb/tb_ofmap_bram_reader.sv
// Directed and randomized bench for ofmap_bram_reader against a word-order
// reference model of the mem2 drain stream.
module tb_ofmap_bram_reader;
  import gemm_pkg::*;

  localparam int AW    = MEM2_ADDR_WIDTH;
  localparam int DW    = MEM2_DATA_WIDTH;
  localparam int DEPTH = MEM2_DEPTH;
  typedef logic [AW:0] nw_t;

  logic          clk;
  logic          rst_n;
  logic          start_i;
  logic [AW:0]   num_words_i;
  logic          mem2_ce1;
  logic          mem2_we1;
  logic [AW-1:0] mem2_addr1;
  logic [DW-1:0] mem2_q1_i;
  logic          m_valid_o;
  logic [DW-1:0] m_data_o;
  logic          m_last_o;
  logic          m_ready_i;
  logic          busy_o;
  logic          done_o;

  logic [DW-1:0] mem2 [DEPTH];

  int            vecCount;
  int            errCount;
  int            cycleCnt;
  int            startCycle;
  int            nEff;
  int            issueCnt;
  int            acceptCnt;
  bit            modelActive;
  bit            doneDue;
  bit            prevStall;
  bit            firstSeen;
  bit            sawDone;
  bit            readyRandom;
  logic [DW-1:0] prevData;

  ofmap_bram_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .num_words_i(num_words_i),
    .mem2_ce1   (mem2_ce1),
    .mem2_we1   (mem2_we1),
    .mem2_addr1 (mem2_addr1),
    .mem2_q1_i  (mem2_q1_i),
    .m_valid_o  (m_valid_o),
    .m_data_o   (m_data_o),
    .m_last_o   (m_last_o),
    .m_ready_i  (m_ready_i),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  // Port-1 BRAM model: one-cycle read latency, garbage when not enabled.
  always @(posedge clk) begin
    if (mem2_ce1 && (mem2_addr1 < AW'(DEPTH))) mem2_q1_i <= mem2[mem2_addr1];
    else mem2_q1_i <= DW'({$urandom, $urandom, $urandom, $urandom});
  end

  function automatic logic [DW-1:0] expWord(input int idx);
    logic [7:0] b;
    b = idx[7:0];
    return {PE_SIZE{b}};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecCount++;
    assert (obs === exp) else begin
      errCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, then sample and
  // compare against the model before the next rising edge.
  task automatic applyStimulus(input bit st, input nw_t nw);
    bit rdy;
    bit pop;
    bit nextDone;
    rdy = readyRandom ? bit'($urandom_range(0, 1)) : 1'b1;
    m_ready_i   = rdy;
    start_i     = st;
    num_words_i = nw;
    #1;
    pop      = m_valid_o & rdy;
    nextDone = 1'b0;
    checkOutput("we1_zero", mem2_we1, 0);
    checkOutput("busy", busy_o, modelActive);
    checkOutput("done", done_o, doneDue);
    if (done_o) sawDone = 1'b1;
    if (!modelActive) begin
      checkOutput("idle_valid", m_valid_o, 0);
      checkOutput("idle_ce", mem2_ce1, 0);
    end
    if (prevStall) begin
      checkOutput("stall_valid", m_valid_o, 1);
      checkOutput("stall_data", m_data_o, prevData);
    end
    if (mem2_ce1) begin
      checkOutput("rd_addr", mem2_addr1, issueCnt);
      checkOutput("rd_in_range", ({1'b0, mem2_addr1} < nEff), 1);
      checkOutput("rd_credit", ((issueCnt - acceptCnt - int'(pop)) < 2), 1);
      issueCnt++;
    end
    if (m_valid_o) begin
      if (!firstSeen) begin
        checkOutput("first_latency", cycleCnt - startCycle, 3);
        firstSeen = 1'b1;
      end
      checkOutput("data", m_data_o, expWord(acceptCnt));
      checkOutput("last", m_last_o, (acceptCnt == nEff - 1));
      if (pop) begin
        acceptCnt++;
        if (acceptCnt == nEff) nextDone = 1'b1;
      end
    end
    prevStall = m_valid_o & ~rdy;
    prevData  = m_data_o;
    if (doneDue) begin
      modelActive = 1'b0;
    end else if (!modelActive && st) begin
      nEff        = (int'(nw) > DEPTH) ? DEPTH : int'(nw);
      issueCnt    = 0;
      acceptCnt   = 0;
      modelActive = 1'b1;
      startCycle  = cycleCnt;
      firstSeen   = 1'b0;
      if (nEff == 0) nextDone = 1'b1;
    end
    doneDue = nextDone;
    cycleCnt++;
    @(negedge clk);
  endtask

  task automatic resetCycles(input int n);
    rst_n     = 1'b0;
    start_i   = 1'b0;
    m_ready_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      checkOutput("rst_ce1", mem2_ce1, 0);
      checkOutput("rst_we1", mem2_we1, 0);
      checkOutput("rst_addr1", mem2_addr1, 0);
      checkOutput("rst_valid", m_valid_o, 0);
      checkOutput("rst_data", m_data_o, 0);
      checkOutput("rst_last", m_last_o, 0);
      checkOutput("rst_busy", busy_o, 0);
      checkOutput("rst_done", done_o, 0);
      @(negedge clk);
    end
    rst_n       = 1'b1;
    modelActive = 1'b0;
    doneDue     = 1'b0;
    prevStall   = 1'b0;
    sawDone     = 1'b0;
  endtask

  task automatic startRun(input nw_t nw);
    sawDone = 1'b0;
    applyStimulus(1'b1, nw);
  endtask

  task automatic runUntilDone();
    for (int g = 0; g < 4000 && !sawDone; g++) applyStimulus(1'b0, '0);
    checkOutput("done_timeout", sawDone, 1);
    checkOutput("word_count", acceptCnt, nEff);
    checkOutput("issue_count", issueCnt, nEff);
    applyStimulus(1'b0, '0);
  endtask

  task automatic runUntilWord(input int k);
    for (int g = 0; g < 4000 && acceptCnt < k; g++) applyStimulus(1'b0, '0);
    checkOutput("reach_word", (acceptCnt >= k), 1);
  endtask

  initial begin
    clk         = 1'b0;
    rst_n       = 1'b0;
    start_i     = 1'b0;
    num_words_i = '0;
    m_ready_i   = 1'b0;
    vecCount    = 0;
    errCount    = 0;
    cycleCnt    = 0;
    startCycle  = 0;
    nEff        = 0;
    issueCnt    = 0;
    acceptCnt   = 0;
    firstSeen   = 1'b0;
    readyRandom = 1'b0;
    prevData    = '0;
    for (int k = 0; k < DEPTH; k++) mem2[k] = expWord(k);

    resetCycles(2);

    readyRandom = 1'b0;
    startRun(nw_t'(896));
    runUntilDone();

    readyRandom = 1'b1;
    startRun(nw_t'(896));
    runUntilDone();

    readyRandom = 1'b0;
    startRun(nw_t'(1));
    runUntilDone();

    startRun(nw_t'(0));
    runUntilDone();
    startRun(nw_t'(1000));
    runUntilDone();

    readyRandom = 1'b1;
    startRun(nw_t'(896));
    runUntilWord(100);
    applyStimulus(1'b1, nw_t'(5));
    runUntilDone();

    startRun(nw_t'(896));
    runUntilWord(300);
    resetCycles(2);
    startRun(nw_t'(10));
    runUntilDone();

    for (int r = 0; r < 3; r++) begin
      startRun(nw_t'($urandom_range(2, 40)));
      runUntilDone();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
